// File: rtl/edge_pattern_gen_pkg.sv
// Shared definitions for the edge pattern generator.
// Contents:
//   DEF_LEN_W - default width of the high/low phase length fields
//   DEF_CNT_W - default width of the pulse count field
//   state_t   - generator FSM state encoding
package edge_gen_pkg;

  localparam int DEF_LEN_W = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/edge_pattern_gen_phase_counter.sv
// Loadable down-counter that saturates at zero.
// Ports:
//   clk        - clock, posedge
//   reset      - asynchronous active-high reset, clears the count
//   load_i     - load load_val_i this cycle (wins over en_i)
//   load_val_i - value to load
//   en_i       - decrement by one; holds at zero, never wraps
//   zero_o     - count currently reads zero
module edge_phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  localparam logic [W-1:0] ONE = W'(1'b1);

  logic [W-1:0] count_q;

  // Count register: load has priority, decrement stops at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - ONE;
    end else begin
      count_q <= count_q;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/edge_pattern_gen.sv
// Programmable level-waveform generator: on an accepted command it drives
// wave_out as num_pulses pulses of high_len cycles high then low_len cycles
// low, with marker strobes registered alongside each edge.
// Ports:
//   clk, reset               - clock and asynchronous active-high reset
//   start_valid/start_ready  - command handshake (ready only in IDLE)
//   high_len/low_len         - phase lengths in cycles, sampled at accept
//   num_pulses               - pulse count, sampled at accept
//   abort                    - stop the active train (HIGH/LOW only)
//   wave_out                 - generated level
//   rise_mark/fall_mark      - strobes on the first cycle of each new level
//   busy                     - train in progress
//   done                     - one-cycle strobe at normal completion
module edge_pattern_gen
  import edge_gen_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic             abort,
  output logic             wave_out,
  output logic             rise_mark,
  output logic             fall_mark,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_t             state_q, state_d;
  logic               wave_q, wave_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   high_q, high_d;
  logic [LEN_W-1:0]   low_q, low_d;

  logic               ph_load_s, ph_en_s, ph_zero_s;
  logic [LEN_W-1:0]   ph_val_s;
  logic               pc_load_s, pc_en_s, pc_zero_s;
  logic [CNT_W-1:0]   pc_val_s;
  logic               degenerate_s;

  // Any zero field means there is nothing to emit: report done without edges.
  assign degenerate_s = (high_len == '0) || (low_len == '0) || (num_pulses == '0);
  // Pulse counter holds "pulses remaining after the current one".
  assign pc_val_s     = num_pulses - CNT_ONE;

  edge_phase_counter #(.W(LEN_W)) u_phase_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ph_load_s),
    .load_val_i (ph_val_s),
    .en_i       (ph_en_s),
    .zero_o     (ph_zero_s)
  );

  edge_phase_counter #(.W(CNT_W)) u_pulse_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (pc_load_s),
    .load_val_i (pc_val_s),
    .en_i       (pc_en_s),
    .zero_o     (pc_zero_s)
  );

  // Next-state, next-output and counter control decode.
  always_comb begin
    state_d   = state_q;
    wave_d    = 1'b0;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    done_d    = 1'b0;
    high_d    = high_q;
    low_d     = low_q;
    ph_load_s = 1'b0;
    ph_val_s  = high_q - LEN_ONE;
    ph_en_s   = 1'b0;
    pc_load_s = 1'b0;
    pc_en_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          high_d    = high_len;
          low_d     = low_len;
          pc_load_s = 1'b1;
          if (degenerate_s) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = HIGH;
            wave_d    = 1'b1;
            rise_d    = 1'b1;
            ph_load_s = 1'b1;
            ph_val_s  = high_len - LEN_ONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HIGH: begin
        // abort beats the phase transition in the same cycle
        if (abort) begin
          state_d = IDLE;
          fall_d  = wave_q;
        end else if (ph_zero_s) begin
          state_d   = LOW;
          fall_d    = 1'b1;
          ph_load_s = 1'b1;
          ph_val_s  = low_q - LEN_ONE;
        end else begin
          wave_d  = 1'b1;
          ph_en_s = 1'b1;
        end
      end
      LOW: begin
        if (abort) begin
          state_d = IDLE;
          fall_d  = wave_q;
        end else if (ph_zero_s) begin
          if (pc_zero_s) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = HIGH;
            wave_d    = 1'b1;
            rise_d    = 1'b1;
            ph_load_s = 1'b1;
            ph_val_s  = high_q - LEN_ONE;
            pc_en_s   = 1'b1;
          end
        end else begin
          ph_en_s = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched fields and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wave_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      done_q  <= 1'b0;
      high_q  <= '0;
      low_q   <= '0;
    end else begin
      state_q <= state_d;
      wave_q  <= wave_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      done_q  <= done_d;
      high_q  <= high_d;
      low_q   <= low_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q == HIGH) || (state_q == LOW);
  assign wave_out    = wave_q;
  assign rise_mark   = rise_q;
  assign fall_mark   = fall_q;
  assign done        = done_q;

endmodule

// File: tb/tb_edge_pattern_gen.sv
// Self-checking bench for edge_pattern_gen. A timeline model describes the
// active train (start cycle, lengths, optional abort cut) and derives every
// output for any cycle with plain arithmetic; a small edge detector on
// wave_out is cross-checked against the markers one cycle later.
module tb_edge_pattern_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] high_len = 8'd0;
  logic [7:0] low_len = 8'd0;
  logic [7:0] num_pulses = 8'd0;
  logic       abort = 1'b0;
  logic       wave_out, rise_mark, fall_mark, busy, done;

  always #5 clk = ~clk;

  edge_pattern_gen #(.LEN_W(8), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .high_len    (high_len),
    .low_len     (low_len),
    .num_pulses  (num_pulses),
    .abort       (abort),
    .wave_out    (wave_out),
    .rise_mark   (rise_mark),
    .fall_mark   (fall_mark),
    .busy        (busy),
    .done        (done)
  );

  // Downstream edge detector on the generated wire.
  logic det_prev, det_rise, det_fall;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      det_prev <= 1'b0;
      det_rise <= 1'b0;
      det_fall <= 1'b0;
    end else begin
      det_prev <= wave_out;
      det_rise <= wave_out & ~det_prev;
      det_fall <= ~wave_out & det_prev;
    end
  end

  // Model of the current train; cycle t is the period after posedge t.
  int cyc = 0;
  bit tr_valid = 1'b0;
  int tr_s, tr_h, tr_l, tr_len;
  int tr_cut = 32'h7fffffff;
  bit cut_wave;
  bit prev_rise_exp = 1'b0, prev_fall_exp = 1'b0;
  int n_checks = 0, n_pass = 0, n_fail = 0;

  // Returns {wave, rise, fall, busy, done, ready} expected in cycle t.
  function automatic logic [5:0] model_at(input int t);
    int idx, p;
    logic w, r, f, b, d, rd;
    w = 1'b0; r = 1'b0; f = 1'b0; b = 1'b0; d = 1'b0; rd = 1'b1;
    if (tr_valid) begin
      if (t >= tr_cut) begin
        f = (t == tr_cut) && cut_wave;
      end else begin
        idx = t - tr_s;
        if (idx >= 0 && idx < tr_len) begin
          p  = idx % (tr_h + tr_l);
          w  = (p < tr_h);
          r  = (p == 0);
          f  = (p == tr_h);
          b  = 1'b1;
          rd = 1'b0;
        end else if (idx == tr_len) begin
          d  = 1'b1;
          rd = 1'b0;
        end
      end
    end
    return {w, r, f, b, d, rd};
  endfunction

  task automatic check(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0b expected %0b", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_idle_reset();
    check("rst_wave", wave_out, 1'b0);
    check("rst_rise", rise_mark, 1'b0);
    check("rst_fall", fall_mark, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", start_ready, 1'b1);
  endtask

  // One clock: update the model with the inputs the DUT samples, then compare.
  task automatic step();
    logic [5:0] prev, cur;
    @(posedge clk);
    cyc++;
    prev = model_at(cyc - 1);
    if (abort && prev[2]) begin
      tr_cut   = cyc;
      cut_wave = prev[5];
    end else if (start_valid && prev[0]) begin
      tr_valid = 1'b1;
      tr_s     = cyc;
      tr_h     = int'(high_len);
      tr_l     = int'(low_len);
      tr_len   = (high_len == 8'd0 || low_len == 8'd0 || num_pulses == 8'd0)
                 ? 0 : int'(num_pulses) * (tr_h + tr_l);
      tr_cut   = 32'h7fffffff;
    end
    #1;
    cur = model_at(cyc);
    check("wave", wave_out, cur[5]);
    check("rise_mark", rise_mark, cur[4]);
    check("fall_mark", fall_mark, cur[3]);
    check("busy", busy, cur[2]);
    check("done", done, cur[1]);
    check("start_ready", start_ready, cur[0]);
    check("det_rise", det_rise, prev_rise_exp);
    check("det_fall", det_fall, prev_fall_exp);
    prev_rise_exp = cur[4];
    prev_fall_exp = cur[3];
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic issue(input int h, input int l, input int n);
    start_valid = 1'b1;
    high_len    = 8'(h);
    low_len     = 8'(l);
    num_pulses  = 8'(n);
    step();
    start_valid = 1'b0;
  endtask

  initial begin
    // power-on reset, released between edges
    #1;
    check_idle_reset();
    repeat (2) @(posedge clk);
    #2;
    check_idle_reset();
    reset = 1'b0;

    // basic train 3/2 x4, then idle margin
    issue(3, 2, 4);
    run(24);

    // 1/1 x3 with start_valid held and fields changed: second command
    // is accepted at the first ready cycle with the then-current fields
    start_valid = 1'b1;
    high_len = 8'd1; low_len = 8'd1; num_pulses = 8'd3;
    step();
    high_len = 8'd2; low_len = 8'd3; num_pulses = 8'd2;
    run(8);
    start_valid = 1'b0;
    run(14);

    // degenerate commands
    issue(0, 3, 2); run(3);
    issue(3, 0, 2); run(3);
    issue(3, 2, 0); run(3);

    // abort during HIGH, then during LOW
    issue(5, 5, 10); run(2);
    abort = 1'b1; step(); abort = 1'b0;
    run(5);
    issue(5, 5, 10); run(6);
    abort = 1'b1; step(); abort = 1'b0;
    run(5);

    // maximum phase length
    issue(255, 1, 1);
    run(260);

    // randomized commands, holds and occasional aborts
    for (int i = 0; i < 60; i++) begin
      start_valid = ($urandom_range(0, 2) != 0);
      high_len    = 8'($urandom_range(0, 6));
      low_len     = 8'($urandom_range(0, 6));
      num_pulses  = 8'($urandom_range(0, 4));
      abort       = ($urandom_range(0, 15) == 0);
      run(int'($urandom_range(1, 12)));
    end
    start_valid = 1'b0;
    abort = 1'b0;
    run(80);

    // asynchronous reset in the middle of a HIGH phase
    issue(4, 3, 2);
    run(1);
    #3 reset = 1'b1;
    #1;
    check("async_wave", wave_out, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_done", done, 1'b0);
    @(posedge clk);
    #2;
    check_idle_reset();
    reset = 1'b0;
    cyc++;
    tr_valid = 1'b0;
    prev_rise_exp = 1'b0;
    prev_fall_exp = 1'b0;

    // after reset the basic train behaves as before
    issue(3, 2, 4);
    run(24);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
